code_entry_ctrl: RTL and testbench

Keypad-side controller for the door lock; sits directly upstream of the 8-entry x 8-bit register file.
- Drives the file's write port (we3/wa3/wd3) to store the password in entries 1..CODE_LEN.
- Reads the stored password back through read port 1 (ra1/rd1).
- Collects typed digits, compares them against the stored code, and reports unlock or error.
- While unlocked, supports reprogramming the password.

---
 rtl/code_entry_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_code_entry_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_ctrl.sv
// Door-lock keypad controller: stores the code in register-file entries 1..CODE_LEN,
// checks typed codes in constant time and allows reprogramming. CODE_LOCKOUT_EN adds a timed lockout.
module code_entry_ctrl #(
  parameter int                    CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                    MAX_FAIL     = 3,
  parameter int                    LOCK_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [7:0] rd1,
  output logic [2:0] ra1,
  output logic       we3,
  output logic [2:0] wa3,
  output logic [7:0] wd3,
  output logic       unlocked,
  output logic       err,
  output logic       busy,
  output logic [2:0] digit_cnt,
  output logic       locked_out
);

`ifdef CODE_LOCKOUT_EN
  localparam bit LOCKOUT_ON = 1'b1;
`else
  localparam bit LOCKOUT_ON = 1'b0;
`endif
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_COMPARE, S_OPEN, S_PROG, S_COMMIT, S_LOCKOUT
  } state_t;

  state_t         r_state;
  logic [3:0]     r_buf [0:7];
  logic [3:0]     r_idx;
  logic           r_match;
  logic [2:0]     r_fail;
  logic [LCW-1:0] r_lock_cnt;

  logic       w_digit, w_clear, w_enter, w_prog, w_trip;
  logic [2:0] w_fail_nxt;
  logic [3:0] w_src;
  logic [3:0] w_def [0:7];

  assign w_digit = key_valid && (key_code <= 4'h9);
  assign w_clear = key_valid && (key_code == 4'hA);
  assign w_enter = key_valid && (key_code == 4'hB);
  assign w_prog  = key_valid && (key_code == 4'hC);

  assign w_fail_nxt = (r_fail == 3'd7) ? 3'd7 : r_fail + 3'd1;
  assign w_trip     = LOCKOUT_ON && (int'(w_fail_nxt) >= MAX_FAIL);

  // Default code unpacked per digit; first digit lives in the top nibble.
  for (genvar g = 0; g < 8; g++) begin : g_def
    if (g < CODE_LEN) begin : g_used
      assign w_def[g] = DEFAULT_CODE[4*(CODE_LEN-1-g) +: 4];
    end else begin : g_pad
      assign w_def[g] = 4'h0;
    end
  end

  assign w_src = (r_state == S_INIT) ? w_def[r_idx[2:0]] : r_buf[r_idx[2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT;
      ra1        <= '0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      unlocked   <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      digit_cnt  <= '0;
      locked_out <= 1'b0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
      r_idx      <= '0;
      r_match    <= 1'b0;
      r_fail     <= '0;
      r_lock_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (r_state)
        S_INIT, S_COMMIT: begin
          if (r_idx < 4'(CODE_LEN)) begin
            we3   <= 1'b1;
            wa3   <= r_idx[2:0] + 3'd1;
            wd3   <= {4'h0, w_src};
            r_idx <= r_idx + 4'd1;
            busy  <= 1'b1;
          end else begin
            we3       <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            busy      <= 1'b0;
            r_idx     <= '0;
            digit_cnt <= '0;
            r_state   <= (r_state == S_INIT) ? S_IDLE : S_OPEN;
          end
        end
        S_IDLE: begin
          if (w_digit) begin
            if (digit_cnt < 3'(CODE_LEN)) begin
              r_buf[digit_cnt] <= key_code;
              digit_cnt        <= digit_cnt + 3'd1;
            end else begin
              err <= 1'b1;
            end
          end else if (w_clear) begin
            digit_cnt <= '0;
          end else if (w_enter) begin
            if (digit_cnt != 3'(CODE_LEN)) begin
              digit_cnt <= '0;
              err       <= 1'b1;
              r_fail    <= w_fail_nxt;
              if (w_trip) begin
                r_state    <= S_LOCKOUT;
                locked_out <= 1'b1;
                busy       <= 1'b1;
                r_lock_cnt <= '0;
              end
            end else begin
              r_state <= S_COMPARE;
              r_idx   <= 4'd1;
              r_match <= 1'b1;
              ra1     <= 3'd1;
              busy    <= 1'b1;
            end
          end else if (w_prog) begin
            err <= 1'b1;
          end
        end
        S_COMPARE: begin
          // Every digit is read even after a miss so timing leaks nothing.
          if (r_idx <= 4'(CODE_LEN)) begin
            if (rd1 != {4'h0, r_buf[r_idx[2:0] - 3'd1]}) r_match <= 1'b0;
            r_idx <= r_idx + 4'd1;
            if (r_idx < 4'(CODE_LEN)) ra1 <= r_idx[2:0] + 3'd1;
          end else begin
            ra1       <= '0;
            r_idx     <= '0;
            digit_cnt <= '0;
            if (r_match) begin
              r_state  <= S_OPEN;
              unlocked <= 1'b1;
              r_fail   <= '0;
              busy     <= 1'b0;
            end else begin
              err    <= 1'b1;
              r_fail <= w_fail_nxt;
              if (w_trip) begin
                r_state    <= S_LOCKOUT;
                locked_out <= 1'b1;
                r_lock_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end
            end
          end
        end
        S_OPEN: begin
          if (w_enter) begin
            r_state  <= S_IDLE;
            unlocked <= 1'b0;
          end else if (w_prog) begin
            r_state   <= S_PROG;
            digit_cnt <= '0;
          end
        end
        S_PROG: begin
          if (w_digit) begin
            r_buf[digit_cnt] <= key_code;
            digit_cnt        <= digit_cnt + 3'd1;
            if (digit_cnt == 3'(CODE_LEN - 1)) begin
              r_state <= S_COMMIT;
              r_idx   <= '0;
              busy    <= 1'b1;
            end
          end else if (w_clear) begin
            r_state   <= S_OPEN;
            digit_cnt <= '0;
          end else if (w_enter) begin
            r_state   <= S_OPEN;
            digit_cnt <= '0;
            err       <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (r_lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            locked_out <= 1'b0;
            busy       <= 1'b0;
            r_fail     <= '0;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed plan steps then random key episodes, all checked
// against a key-level model of the lock; the 8x8 register file is modelled here.
module tb_code_entry_ctrl;
  localparam int              CL   = 4;
  localparam logic [15:0]     DEF  = 16'h1234;
  localparam int              MAXF = 3;
  localparam int              LCYC = 20;
`ifdef CODE_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] rd1;
  logic [2:0] ra1, wa3, digit_cnt;
  logic       we3, unlocked, err, busy, locked_out;
  logic [7:0] wd3;

  code_entry_ctrl #(.CODE_LEN(CL), .DEFAULT_CODE(DEF), .MAX_FAIL(MAXF), .LOCK_CYCLES(LCYC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .rd1(rd1),
    .ra1(ra1), .we3(we3), .wa3(wa3), .wd3(wd3), .unlocked(unlocked), .err(err),
    .busy(busy), .digit_cnt(digit_cnt), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  // register file behind the controller
  logic [7:0] rf [0:7];
  int cyc = 0;
  assign rd1 = rf[ra1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we3) rf[wa3] <= wd3;
  end

  int wq_a[$], wq_d[$], wq_c[$];
  int err_cnt = 0, lock_cyc = 0, rise_cyc = -1, bad_wa = 0;
  logic unl_q = 1'b0;
  always @(negedge clk) begin
    if (we3) begin
      wq_a.push_back(int'(wa3)); wq_d.push_back(int'(wd3)); wq_c.push_back(cyc);
      if (wa3 == 3'd0) bad_wa++;
    end
    if (err) err_cnt++;
    if (locked_out) lock_cyc++;
    if (unlocked && !unl_q) rise_cyc = cyc;
    unl_q = unlocked;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // key-level model: mode 0 locked, 1 open, 2 programming
  int m_code[CL];
  int m_buf[$];
  int m_mode, m_fails, lock_base;
  bit m_trip;

  task automatic model_reset();
    for (int i = 0; i < CL; i++) m_code[i] = int'((DEF >> (4*(CL-1-i))) & 16'hF);
    m_buf.delete(); m_mode = 0; m_fails = 0; m_trip = 0;
  endtask

  task automatic model_fail();
    m_fails = (m_fails < 7) ? m_fails + 1 : 7;
    if (LOCK_ON && m_fails >= MAXF) begin m_trip = 1; m_fails = 0; end
  endtask

  task automatic model_key(input int k, output int e);
    bit eq;
    e = 0;
    case (m_mode)
      0: begin
        if (k <= 9) begin
          if (m_buf.size() < CL) m_buf.push_back(k); else e = 1;
        end else if (k == 10) m_buf.delete();
        else if (k == 11) begin
          if (m_buf.size() != CL) begin e = 1; model_fail(); end
          else begin
            eq = 1;
            for (int i = 0; i < CL; i++) if (m_buf[i] != m_code[i]) eq = 0;
            if (eq) begin m_mode = 1; m_fails = 0; end
            else begin e = 1; model_fail(); end
          end
          m_buf.delete();
        end else if (k == 12) e = 1;
      end
      1: begin
        if (k == 11) m_mode = 0;
        else if (k == 12) begin m_mode = 2; m_buf.delete(); end
      end
      default: begin
        if (k <= 9) begin
          m_buf.push_back(k);
          if (m_buf.size() == CL) begin
            for (int i = 0; i < CL; i++) m_code[i] = m_buf[i];
            m_mode = 1; m_buf.delete();
          end
        end else if (k == 10) begin m_mode = 1; m_buf.delete(); end
        else if (k == 11) begin e = 1; m_mode = 1; m_buf.delete(); end
      end
    endcase
  endtask

  task automatic drive(input logic [3:0] k);
    @(negedge clk); key_valid = 1'b1; key_code = k;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic clr_logs();
    @(posedge clk); #1;
    wq_a.delete(); wq_d.delete(); wq_c.delete();
  endtask

  task automatic press(input logic [3:0] k);
    int e, e0;
    model_key(int'(k), e);
    e0 = err_cnt; lock_base = lock_cyc;
    drive(k);
    repeat (CL + 3) @(negedge clk);
    chk("err_pulses", err_cnt - e0, e);
    chk("unlocked", int'(unlocked), int'(m_mode != 0));
    chk("digit_cnt", int'(digit_cnt), m_buf.size());
    chk("locked_out", int'(locked_out), int'(m_trip));
    chk("busy", int'(busy), int'(m_trip));
    for (int i = 1; i <= CL; i++) chk("rf_code", int'(rf[i]), m_code[i-1]);
  endtask

  task automatic finish_lockout();
    for (int i = 0; i < LCYC + 20; i++) begin
      if (!locked_out) break;
      @(negedge clk);
    end
    chk("lock_len", lock_cyc - lock_base, LCYC);
    chk("lock_busy", int'(busy), 0);
    m_trip = 0;
  endtask

  task automatic press_r(input logic [3:0] k);
    press(k);
    if (m_trip) finish_lockout();
  endtask

  task automatic chk_wr();
    chk("wr_count", wq_a.size(), CL);
    for (int i = 0; i < CL && i < wq_a.size(); i++) begin
      chk("wr_addr", wq_a[i], i + 1);
      chk("wr_data", wq_d[i], m_code[i]);
      chk("wr_cycle", wq_c[i] - wq_c[0], i);
    end
  endtask

  task automatic wait_init();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && wq_a.size() >= CL) break;
    end
    chk("init_busy", int'(busy), 0);
    chk_wr();
  endtask

  initial begin
    int e0, ecyc;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    model_reset();

    // reset state and default-code load
    repeat (2) @(negedge clk);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we3", int'(we3), 0);
    chk("rst_cnt", int'(digit_cnt), 0);
    chk("rst_lock", int'(locked_out), 0);
    chk("rst_ra1", int'(ra1), 0);
    clr_logs();
    @(negedge clk); rst = 1'b0;
    wait_init();

    // correct code: read-address walk and unlock latency
    for (int i = 1; i <= CL; i++) press(4'(i));
    model_key(11, e0);
    e0 = err_cnt;
    drive(4'hB);
    ecyc = cyc;
    for (int i = 1; i <= CL; i++) begin
      chk("ra1_step", int'(ra1), i);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("unlock_latency", rise_cyc - ecyc, CL + 1);
    chk("unlock", int'(unlocked), 1);
    chk("unlock_no_err", err_cnt - e0, 0);
    press(4'hB);

    // wrong code, then short code
    press(4'h1); press(4'h2); press(4'h3); press(4'h5); press(4'hB);
    press(4'h1); press(4'h2); press(4'hB);

    // unlock, reprogram to 9876, relock, check old and new codes
    for (int i = 1; i <= CL; i++) press(4'(i));
    press(4'hB);
    press(4'hC); press(4'h9); press(4'h8); press(4'h7);
    clr_logs();
    press(4'h6);
    chk_wr();
    press(4'hB);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hB);
    press(4'hB);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);

    // repeated failures; with lockout the right code is ignored until it expires
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < CL; i++) press(4'h0);
      press(4'hB);
    end
    if (m_trip) begin
      e0 = err_cnt;
      for (int i = 0; i < CL; i++) drive(4'(m_code[i]));
      drive(4'hB);
      chk("lock_ignore_unl", int'(unlocked), 0);
      chk("lock_ignore_err", err_cnt - e0, 0);
      chk("lock_ignore_cnt", int'(digit_cnt), 0);
      finish_lockout();
    end
    for (int i = 0; i < CL; i++) press(4'(m_code[i]));
    press(4'hB);

    // reset during compare of a correct code restores the default
    press(4'hB);
    for (int i = 0; i < CL; i++) press(4'(m_code[i]));
    drive(4'hB);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst_unl", int'(unlocked), 0);
    chk("midrst_busy", int'(busy), 0);
    clr_logs();
    @(negedge clk); rst = 1'b0;
    model_reset();
    wait_init();
    chk("post_rst_unl", int'(unlocked), 0);
    for (int i = 0; i < CL; i++) press(4'(m_code[i]));
    press(4'hB);

    // random episodes
    for (int ep = 0; ep < 50; ep++) begin
      case ($urandom_range(0, 4))
        0: begin
          for (int i = 0; i < CL; i++) press_r(4'(m_code[i]));
          press_r(4'hB);
        end
        1: begin
          for (int i = 0; i < CL; i++) press_r(4'($urandom_range(0, 9)));
          press_r(4'hB);
        end
        2: press_r(4'($urandom_range(0, 15)));
        3: begin
          press_r(4'hC);
          for (int i = 0; i < CL; i++) press_r(4'($urandom_range(0, 9)));
        end
        default: press_r(4'hB);
      endcase
    end

    chk("wa3_nonzero", bad_wa, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
